// File: rtl/conv_layer_loader.sv
// Streams activation words, then weight words, into a conv_layer as indexed write strobes.
// It then holds compute for the MAC cycle count. Optional XOR checksum: CONV_LOADER_CHECKSUM_EN.
module conv_layer_loader #(
   parameter int NUM_INPUTS  = 1,
   parameter int NUM_OUTPUTS = 1,
   parameter int INPUT_DIM   = 5,
   parameter int KERNEL_DIM  = 3,
   parameter int DATA_SIZE   = 64,
   parameter int OUTPUT_DIM  = INPUT_DIM - KERNEL_DIM + 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [DATA_SIZE-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 want_write_act,
   output logic                 want_write_weights,
   output logic [DATA_SIZE-1:0] write_data,
   output logic [15:0]          in_index3,
   output logic [15:0]          in_index2,
   output logic [15:0]          in_index1,
   output logic [15:0]          in_index0,
   output logic                 compute,
   output logic                 busy,
   output logic                 done
`ifdef CONV_LOADER_CHECKSUM_EN
   ,
   output logic [DATA_SIZE-1:0] checksum
`endif
);
   localparam logic [31:0] COMPUTE_CYCLES =
      32'(NUM_INPUTS * NUM_OUTPUTS * OUTPUT_DIM * OUTPUT_DIM * KERNEL_DIM * KERNEL_DIM);
   localparam logic [15:0] IN_LAST  = 16'(NUM_INPUTS - 1);
   localparam logic [15:0] OUT_LAST = 16'(NUM_OUTPUTS - 1);
   localparam logic [15:0] ACT_LAST = 16'(INPUT_DIM - 1);
   localparam logic [15:0] KER_LAST = 16'(KERNEL_DIM - 1);

   typedef enum logic [2:0] {IDLE, LOAD_ACT, LOAD_WGT, COMPUTE, DONE} state_t;

   state_t      state_reg;
   logic [15:0] cnt_reg [4];
   logic [15:0] lim [4];
   logic [4:0]  carry;
   logic [31:0] cycle_reg;
   logic        beat;

   assign in_ready = (state_reg == LOAD_ACT) || (state_reg == LOAD_WGT);
   assign busy     = (state_reg != IDLE);
   assign beat     = in_ready && in_valid;

   // Activation phase keeps the top counter pinned at 0 so one carry chain serves both phases.
   always_comb begin
      lim[0] = KER_LAST;
      lim[1] = KER_LAST;
      lim[2] = OUT_LAST;
      lim[3] = IN_LAST;
      if (state_reg == LOAD_ACT) begin
         lim[0] = ACT_LAST;
         lim[1] = ACT_LAST;
         lim[2] = IN_LAST;
         lim[3] = 16'd0;
      end
   end

   assign carry[0] = beat;
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_carry
         assign carry[gi+1] = carry[gi] && (cnt_reg[gi] == lim[gi]);
      end
   endgenerate

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (reset || state_reg == IDLE || carry[4])
            cnt_reg[i] <= '0;
         else if (carry[i])
            cnt_reg[i] <= (cnt_reg[i] == lim[i]) ? 16'd0 : cnt_reg[i] + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg          <= IDLE;
         cycle_reg          <= '0;
         want_write_act     <= 1'b0;
         want_write_weights <= 1'b0;
         write_data         <= '0;
         in_index3          <= '0;
         in_index2          <= '0;
         in_index1          <= '0;
         in_index0          <= '0;
         compute            <= 1'b0;
         done               <= 1'b0;
      end else begin
         want_write_act     <= 1'b0;
         want_write_weights <= 1'b0;
         done               <= 1'b0;
         if (beat) begin
            write_data <= in_data;
            in_index3  <= cnt_reg[3];
            in_index2  <= cnt_reg[2];
            in_index1  <= cnt_reg[1];
            in_index0  <= cnt_reg[0];
            if (state_reg == LOAD_ACT)
               want_write_act <= 1'b1;
            else
               want_write_weights <= 1'b1;
         end
         case (state_reg)
            IDLE:     if (start) state_reg <= LOAD_ACT;
            LOAD_ACT: if (carry[4]) state_reg <= LOAD_WGT;
            LOAD_WGT: if (carry[4]) begin
                         state_reg <= COMPUTE;
                         cycle_reg <= '0;
                      end
            // First COMPUTE cycle carries the last weight strobe, so compute rises one cycle later.
            COMPUTE:  if (cycle_reg == COMPUTE_CYCLES) begin
                         compute   <= 1'b0;
                         done      <= 1'b1;
                         state_reg <= DONE;
                      end else begin
                         compute   <= 1'b1;
                         cycle_reg <= cycle_reg + 32'd1;
                      end
            DONE:     state_reg <= IDLE;
            default:  state_reg <= IDLE;
         endcase
      end
   end

`ifdef CONV_LOADER_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (reset)
         checksum <= '0;
      else if (state_reg == IDLE && start)
         checksum <= '0;
      else if (beat)
         checksum <= checksum ^ in_data;
   end
`endif

endmodule

// File: tb/tb_conv_layer_loader.sv
// Directed bench: default geometry (dut_a) and a 2x2x4x2 geometry (dut_b) share one input stream.
`timescale 1ns/1ps
module tb_conv_layer_loader;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b1;
   logic        start_a = 1'b0, start_b = 1'b0, in_valid = 1'b0;
   logic [63:0] in_data = '0;

   logic        a_ready, a_wa, a_ww, a_comp, a_busy, a_done;
   logic [63:0] a_wd;
   logic [15:0] a_i3, a_i2, a_i1, a_i0;
   logic        b_ready, b_wa, b_ww, b_comp, b_busy, b_done;
   logic [63:0] b_wd;
   logic [15:0] b_i3, b_i2, b_i1, b_i0;
`ifdef CONV_LOADER_CHECKSUM_EN
   logic [63:0] a_sum, b_sum;
`endif

   conv_layer_loader dut_a (
      .clk(clk), .reset(reset), .start(start_a), .in_data(in_data), .in_valid(in_valid),
      .in_ready(a_ready), .want_write_act(a_wa), .want_write_weights(a_ww), .write_data(a_wd),
      .in_index3(a_i3), .in_index2(a_i2), .in_index1(a_i1), .in_index0(a_i0),
      .compute(a_comp), .busy(a_busy), .done(a_done)
`ifdef CONV_LOADER_CHECKSUM_EN
      , .checksum(a_sum)
`endif
   );

   conv_layer_loader #(.NUM_INPUTS(2), .NUM_OUTPUTS(2), .INPUT_DIM(4), .KERNEL_DIM(2)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .in_data(in_data), .in_valid(in_valid),
      .in_ready(b_ready), .want_write_act(b_wa), .want_write_weights(b_ww), .write_data(b_wd),
      .in_index3(b_i3), .in_index2(b_i2), .in_index1(b_i1), .in_index0(b_i0),
      .compute(b_comp), .busy(b_busy), .done(b_done)
`ifdef CONV_LOADER_CHECKSUM_EN
      , .checksum(b_sum)
`endif
   );

   bit          sel = 1'b0;
   logic        m_ready, m_wa, m_ww, m_comp, m_busy, m_done;
   logic [63:0] m_wd;
   logic [15:0] m_i3, m_i2, m_i1, m_i0;
   assign m_ready = sel ? b_ready : a_ready;
   assign m_wa    = sel ? b_wa    : a_wa;
   assign m_ww    = sel ? b_ww    : a_ww;
   assign m_comp  = sel ? b_comp  : a_comp;
   assign m_busy  = sel ? b_busy  : a_busy;
   assign m_done  = sel ? b_done  : a_done;
   assign m_wd    = sel ? b_wd    : a_wd;
   assign m_i3    = sel ? b_i3    : a_i3;
   assign m_i2    = sel ? b_i2    : a_i2;
   assign m_i1    = sel ? b_i1    : a_i1;
   assign m_i0    = sel ? b_i0    : a_i0;

   int total_cnt = 0;
   int bad_cnt   = 0;
   int word_mode = 0;

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] word(input int n);
      if (word_mode == 1) return 64'(n + 1);
      return $realtobits(real'(n + 1));
   endfunction

   task automatic set_start(input bit v);
      if (sel) start_b = v; else start_a = v;
   endtask

   // One full load+compute sequence on the selected DUT; every strobe is checked against its ordinal.
   task automatic run_seq(input int ni, input int no, input int d, input int k,
                          input bit toggle, input bit poke);
      int act_n, wgt_n, comp_n, total, sent, got, cyc, ccount, od, w;
      bit beat_prev;
      act_n  = ni * d * d;
      wgt_n  = ni * no * k * k;
      od     = d - k + 1;
      comp_n = ni * no * od * od * k * k;
      total  = act_n + wgt_n;
      sent = 0; got = 0; cyc = 0; ccount = 0; beat_prev = 1'b0;
      @(negedge clk);
      set_start(1'b1);
      @(negedge clk);
      set_start(1'b0);
      check_val("busy_after_start", 128'(m_busy), 128'(1));
      while (got < total) begin
         if (cyc > 4 * total + 20) begin
            check_val("load_timeout", 128'(got), 128'(total));
            break;
         end
         if (beat_prev) begin
            if (got < act_n) begin
               check_val("act_strobe", 128'({m_wa, m_ww, m_i3, m_i2, m_i1, m_i0}),
                         128'({1'b1, 1'b0, 16'd0, 16'(got / (d * d)), 16'((got / d) % d), 16'(got % d)}));
            end else begin
               w = got - act_n;
               check_val("wgt_strobe", 128'({m_wa, m_ww, m_i3, m_i2, m_i1, m_i0}),
                         128'({1'b0, 1'b1, 16'(w / (k * k * no)), 16'((w / (k * k)) % no),
                               16'((w / k) % k), 16'(w % k)}));
            end
            check_val("write_data", 128'(m_wd), 128'(word(got)));
            got++;
         end else begin
            check_val("no_strobe", 128'({m_wa, m_ww}), 128'(0));
         end
         set_start(poke && got == act_n + 1);
         in_valid  = (sent < total) && (!toggle || (cyc % 2 == 0));
         in_data   = word(sent);
         beat_prev = in_valid && m_ready;
         if (beat_prev) sent++;
         cyc++;
         @(negedge clk);
      end
      set_start(1'b0);
      in_valid = 1'b0;
      while (m_comp && ccount < comp_n + 10) begin
         set_start(poke && ccount == 5);
         check_val("ready_in_compute", 128'(m_ready), 128'(0));
         ccount++;
         @(negedge clk);
      end
      set_start(1'b0);
      check_val("compute_cycles", 128'(ccount), 128'(comp_n));
      check_val("done_pulse", 128'({m_done, m_comp}), 128'(2'b10));
      @(negedge clk);
      check_val("back_to_idle", 128'({m_done, m_busy, m_ready}), 128'(0));
   endtask

   initial begin
      logic [63:0] exp_sum;
      repeat (3) @(negedge clk);
      check_val("reset_state_a", 128'({a_ready, a_wa, a_ww, a_comp, a_busy, a_done, a_wd, a_i3, a_i2, a_i1, a_i0}), 128'(0));
      check_val("reset_state_b", 128'({b_ready, b_wa, b_ww, b_comp, b_busy, b_done, b_wd, b_i3, b_i2, b_i1, b_i0}), 128'(0));
      reset = 1'b0;

      // Valid words offered while idle must not be taken.
      in_valid = 1'b1;
      in_data  = 64'hdead_beef;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_val("idle_ignore", 128'({a_ready, a_wa, a_ww, b_ready, b_wa, b_ww}), 128'(0));
      end
      in_valid = 1'b0;

      sel = 1'b0;
      run_seq(1, 1, 5, 3, 1'b0, 1'b0);
      run_seq(1, 1, 5, 3, 1'b1, 1'b1);

      // Abort a partial activation load, then confirm a clean restart.
      @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a  = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_data = word(i);
         @(negedge clk);
      end
      in_valid = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
      check_val("mid_reset", 128'({a_ready, a_wa, a_ww, a_comp, a_busy, a_done, a_wd, a_i3, a_i2, a_i1, a_i0}), 128'(0));
      reset = 1'b0;
      run_seq(1, 1, 5, 3, 1'b0, 1'b0);

      sel = 1'b1;
      run_seq(2, 2, 4, 2, 1'b0, 1'b0);
      check_val("b_last_wgt_index", 128'({b_i3, b_i2, b_i1, b_i0}), 128'({16'd1, 16'd1, 16'd1, 16'd1}));

`ifdef CONV_LOADER_CHECKSUM_EN
      sel       = 1'b0;
      word_mode = 1;
      run_seq(1, 1, 5, 3, 1'b0, 1'b0);
      exp_sum = '0;
      for (int i = 1; i <= 34; i++) exp_sum = exp_sum ^ 64'(i);
      check_val("checksum", 128'(a_sum), 128'(exp_sum));
`else
      exp_sum = '0;
`endif

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end
endmodule
